// File: rtl/mdio_master_if.sv
// Request/response bundle between the register block and the MDIO master.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready handshake; the response is a one-cycle pulse with no stall.
interface mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_phy_addr;
    logic [4:0]  req_reg_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        input  req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: one register read/write request becomes one MDC/MDIO frame.
// Latency: the response pulse arrives 2*CLK_DIV*(PREAMBLE_LEN+33)+1 cycles after acceptance.
// Backpressure: req_ready is high only when idle; a request held while busy is ignored, not queued.
module mdio_master #(
    parameter int CLK_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    mdio_master_if.master bus,
    output logic          mdc,
    output logic          mdio_o,
    output logic          mdio_oe,
    input  logic          mdio_i
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_END
    } state_t;

    localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
    localparam state_t     START_STATE = (PREAMBLE_LEN > 0) ? S_PRE : S_ST;
    localparam logic [6:0] START_CNT   = (PREAMBLE_LEN > 0) ? 7'(PREAMBLE_LEN - 1) : 7'd1;

    state_t      state;
    state_t      nxt_state;
    logic [7:0]  div_cnt;
    logic [6:0]  bit_cnt;      // MDC periods left in the current state, minus one
    logic [6:0]  nxt_cnt;
    logic        wr_q;
    logic [4:0]  phy_q;
    logic [4:0]  reg_q;
    logic [15:0] wdata_q;
    logic [15:0] rd_sh;
    logic        err_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic        mdc_q;
    logic        mdio_o_q;
    logic        mdio_oe_q;
    logic [1:0]  start_bits;   // {oe, o} for the first period of a new frame
    logic [1:0]  nxt_bits;     // {oe, o} for the period that follows the current one

    // {oe, o} for a given position in the frame; bit_cnt counts down, so it indexes MSB first
    function automatic logic [1:0] drive_bits(input state_t s, input logic [6:0] n,
                                              input logic wr, input logic [4:0] pa,
                                              input logic [4:0] ra, input logic [15:0] wd);
        logic [1:0] r;
        r = 2'b01;
        case (s)
            S_PRE:   r = 2'b11;
            S_ST:    r = {1'b1, ~n[0]};                   // 0 then 1
            S_OP:    r = {1'b1, wr ? ~n[0] : n[0]};       // write 01, read 10
            S_PHYAD: r = {1'b1, pa[n[2:0]]};
            S_REGAD: r = {1'b1, ra[n[2:0]]};
            S_TA:    r = wr ? {1'b1, n[0]} : 2'b01;       // write drives 10, read releases
            S_DATA:  r = wr ? {1'b1, wd[n[3:0]]} : 2'b01;
            default: r = 2'b01;                           // END and IDLE: released, idle-high
        endcase
        return r;
    endfunction

    // Next frame position at the end of the current MDC period
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt - 7'd1;
        if (bit_cnt == 7'd0) begin
            case (state)
                S_PRE:   begin nxt_state = S_ST;    nxt_cnt = 7'd1;  end
                S_ST:    begin nxt_state = S_OP;    nxt_cnt = 7'd1;  end
                S_OP:    begin nxt_state = S_PHYAD; nxt_cnt = 7'd4;  end
                S_PHYAD: begin nxt_state = S_REGAD; nxt_cnt = 7'd4;  end
                S_REGAD: begin nxt_state = S_TA;    nxt_cnt = 7'd1;  end
                S_TA:    begin nxt_state = S_DATA;  nxt_cnt = 7'd15; end
                S_DATA:  begin nxt_state = S_END;   nxt_cnt = 7'd0;  end
                default: begin nxt_state = S_IDLE;  nxt_cnt = 7'd0;  end
            endcase
        end
        start_bits = drive_bits(START_STATE, START_CNT, bus.req_write,
                                bus.req_phy_addr, bus.req_reg_addr, bus.req_wdata);
        nxt_bits   = drive_bits(nxt_state, nxt_cnt, wr_q, phy_q, reg_q, wdata_q);
    end

    // Frame sequencer: MDC divider, pin drive on falling edges, sampling on rising edges
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= 8'd0;
            bit_cnt     <= 7'd0;
            wr_q        <= 1'b0;
            phy_q       <= 5'd0;
            reg_q       <= 5'd0;
            wdata_q     <= 16'd0;
            rd_sh       <= 16'd0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
            rsp_error_q <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.req_valid && ready_q) begin
                    wr_q                   <= bus.req_write;
                    phy_q                  <= bus.req_phy_addr;
                    reg_q                  <= bus.req_reg_addr;
                    wdata_q                <= bus.req_wdata;
                    rd_sh                  <= 16'd0;
                    err_q                  <= 1'b0;
                    state                  <= START_STATE;
                    bit_cnt                <= START_CNT;
                    div_cnt                <= 8'd0;
                    mdc_q                  <= 1'b0;
                    {mdio_oe_q, mdio_o_q}  <= start_bits;
                    ready_q                <= 1'b0;
                end
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= 8'd0;
                mdc_q   <= ~mdc_q;
                if (!mdc_q) begin
                    // Rising edge: capture what the PHY held through the low half
                    if (!wr_q) begin
                        if (state == S_TA && bit_cnt == 7'd0)
                            err_q <= mdio_i;
                        if (state == S_DATA)
                            rd_sh <= {rd_sh[14:0], mdio_i};
                    end
                end else if (state == S_END) begin
                    // Falling edge closing the frame: publish the response
                    state       <= S_IDLE;
                    bit_cnt     <= 7'd0;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= wr_q ? 16'd0 : rd_sh;
                    rsp_error_q <= wr_q ? 1'b0 : err_q;
                    mdio_oe_q   <= 1'b0;
                    mdio_o_q    <= 1'b1;
                end else begin
                    // Falling edge: start the next period and present its bit
                    state                 <= nxt_state;
                    bit_cnt               <= nxt_cnt;
                    {mdio_oe_q, mdio_o_q} <= nxt_bits;
                end
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign mdc           = mdc_q;
    assign mdio_o        = mdio_o_q;
    assign mdio_oe       = mdio_oe_q;
endmodule
